proc_trace_buffer: RTL



---
 rtl/proc_trace_buffer.sv | 113 +++++++++++
 1 files changed

// File: rtl/proc_trace_buffer.sv
// Trace capture FIFO: records (pc, result) pairs from the processor and drains
// them over a val/rdy stream; overflow is counted instead of stalling the core.
module proc_trace_buffer #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 4,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PC_W-1:0]          pc,
    input  logic [DATA_W-1:0]        result,
    input  logic                     capture_en,
    input  logic                     dedup_en,
    input  logic                     clear_ovf,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [PC_W-1:0]          out_pc,
    output logic [DATA_W-1:0]        out_result,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [3:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PC_W+DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [3:0]             drop_count_q, drop_count_d;
    logic [PC_W-1:0]        last_pc_q, last_pc_d;
    logic                   last_valid_q, last_valid_d;

    logic                   dup, req, full, pop, push, drop;
    logic [PC_W+DATA_W-1:0] head;

    always_comb begin
        dup  = dedup_en && last_valid_q && (pc == last_pc_q);
        req  = capture_en && !dup;
        full = (count_q == CNT_FULL);
        pop  = (count_q != '0) && out_rdy;
        push = req && (!full || pop);
        drop = req && full && !pop;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        last_pc_d    = last_pc_q;
        last_valid_d = last_valid_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;

        // A drop in the same cycle as a clear restarts the tally at one.
        if (drop) begin
            overflow_d   = 1'b1;
            if (clear_ovf)                 drop_count_d = 4'd1;
            else if (drop_count_q != 4'hF) drop_count_d = drop_count_q + 4'd1;
        end else if (clear_ovf) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end

        // Dropped pcs still count as seen so stalls on a full buffer do not re-offer them.
        if (req) begin
            last_pc_d    = pc;
            last_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            last_pc_q    <= last_pc_d;
            last_valid_q <= last_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pc, result};
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_val    = (count_q != '0);
        out_pc     = out_val ? head[PC_W+DATA_W-1:DATA_W] : '0;
        out_result = out_val ? head[DATA_W-1:0] : '0;
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
    end
endmodule
